// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program-counter and fetch-control stage in front of a 1-cycle-latency
// instruction memory. Chooses the next PC (sequential, branch, jump or
// jump-register), drives the word index to the memory, and tracks the PC
// and valid bit of the instruction that the memory is presenting to decode.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] imem_addr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        fetch_valid,
    output logic        pc_oor,
    output logic        misalign_err
);

    // Number of word-index bits the memory actually decodes.
    localparam int          IDX_W   = $clog2(IMEM_DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] fetch_pc_reg;
    logic [31:0] fetch_pc_next;
    logic        fetch_valid_reg;
    logic        fetch_valid_next;
    logic        misalign_reg;
    logic        misalign_next;

    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic [31:0] word_index;

    assign redirect    = jr | jump | branch_taken;
    assign pc_plus4    = pc_reg + 32'd4;
    // Jumps are relative to the 256 MB region of the instruction in decode,
    // which is the one whose link value is fetch_pc + 4.
    assign jump_target = {fetch_pc_plus4[31:28], jump_index, 2'b00};
    assign word_index  = {2'b00, pc_reg[31:2]};

    // Select the winning redirect target: jr beats jump beats branch.
    always_comb begin
        redirect_target = branch_target;
        if (jr) begin
            redirect_target = jr_target;
        end else if (jump) begin
            redirect_target = jump_target;
        end
    end

    // Next-state for pc, fetch slot tracking and the sticky misalign flag.
    always_comb begin
        pc_next          = pc_plus4;
        fetch_pc_next    = fetch_pc_reg;
        fetch_valid_next = 1'b1;
        misalign_next    = misalign_reg;

        if (redirect) begin
            // Targets are always loaded word-aligned; a bad low pair is latched.
            pc_next          = {redirect_target[31:2], 2'b00};
            fetch_pc_next    = pc_reg;
            fetch_valid_next = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_next = 1'b1;
            end
        end else if (stall) begin
            pc_next          = pc_reg;
            fetch_pc_next    = fetch_pc_reg;
            fetch_valid_next = fetch_valid_reg;
        end else begin
            pc_next          = pc_plus4;
            fetch_pc_next    = pc_reg;
            fetch_valid_next = 1'b1;
        end
    end

    // State registers with synchronous reset; reset wins over stall and redirects.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            fetch_pc_reg    <= RESET_PC;
            fetch_valid_reg <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            fetch_pc_reg    <= fetch_pc_next;
            fetch_valid_reg <= fetch_valid_next;
            misalign_reg    <= misalign_next;
        end
    end

    // Word index modulo the (power-of-two) memory depth: keep the low IDX_W
    // bits of pc[31:2] and zero the rest, so out-of-range PCs alias.
    for (genvar gi = 0; gi < 32; gi++) begin : g_imem_addr
        if (gi < IDX_W) begin : g_live
            assign imem_addr[gi] = pc_reg[gi+2];
        end else begin : g_zero
            assign imem_addr[gi] = 1'b0;
        end
    end

    assign pc             = pc_reg;
    assign fetch_pc       = fetch_pc_reg;
    assign fetch_pc_plus4 = fetch_pc_reg + 32'd4;
    assign fetch_valid    = fetch_valid_reg;
    assign misalign_err   = misalign_reg;
    // Informational only: fetch continues with the aliased index.
    assign pc_oor         = (word_index >= DEPTH_W);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a directed cycle table with hand-derived
// expectations, then randomized traffic checked against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_DEPTH = 32;
    localparam int          NVEC       = 23;
    localparam int          NRAND      = 600;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] imem_addr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic        fetch_valid;
    logic        pc_oor;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .jr             (jr),
        .jr_target      (jr_target),
        .pc             (pc),
        .imem_addr      (imem_addr),
        .fetch_pc       (fetch_pc),
        .fetch_pc_plus4 (fetch_pc_plus4),
        .fetch_valid    (fetch_valid),
        .pc_oor         (pc_oor),
        .misalign_err   (misalign_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [25:0] ji;
        logic        jrr;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic [31:0] e_imem;
        logic        e_oor;
        logic [31:0] e_fpc;
        logic        e_fv;
        logic        e_mis;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, then let it clock.
    task automatic drive(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                         input logic jmp, input logic [25:0] ji, input logic jrr, input logic [31:0] jt);
        @(negedge clock);
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jmp;
        jump_index    = ji;
        jr            = jrr;
        jr_target     = jt;
        @(posedge clock);
        #1;
    endtask

    // Behavioural model state.
    logic [31:0] m_pc;
    logic [31:0] m_fpc;
    logic        m_fv;
    logic        m_mis;

    task automatic model_step(input logic rst, input logic stl, input logic br, input logic [31:0] bt,
                              input logic jmp, input logic [25:0] ji, input logic jrr, input logic [31:0] jt);
        logic [31:0] tgt;
        logic [31:0] link;
        logic        redir;
        if (rst) begin
            m_pc  = RESET_PC;
            m_fpc = RESET_PC;
            m_fv  = 1'b0;
            m_mis = 1'b0;
            return;
        end
        redir = jrr || jmp || br;
        link  = m_fpc + 32'd4;
        if (jrr)      tgt = jt;
        else if (jmp) tgt = (link & 32'hF000_0000) + (32'(ji) * 32'd4);
        else          tgt = bt;
        if (redir) begin
            if ((tgt % 4) != 0) m_mis = 1'b1;
            m_fpc = m_pc;
            m_fv  = 1'b0;
            m_pc  = tgt - (tgt % 4);
        end else if (!stl) begin
            m_fpc = m_pc;
            m_fv  = 1'b1;
            m_pc  = m_pc + 32'd4;
        end
    endtask

    task automatic compare_model();
        check("pc", pc, m_pc);
        check("imem_addr", imem_addr, (m_pc / 4) % IMEM_DEPTH);
        check("pc_oor", 32'(pc_oor), 32'((m_pc / 4) >= IMEM_DEPTH));
        check("fetch_pc", fetch_pc, m_fpc);
        check("fetch_pc_plus4", fetch_pc_plus4, m_fpc + 32'd4);
        check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        check("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;

        //         rst  stl  br   bt            jmp  ji      jr   jt             pc            imem   oor  fpc           fv   mis
        vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h0,        32'd0, 1'b0,32'h0,        1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h4,        32'd1, 1'b0,32'h0,        1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h8,        32'd2, 1'b0,32'h4,        1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'hC,        32'd3, 1'b0,32'h8,        1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h10,       32'd4, 1'b0,32'hC,        1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b1,32'h40,       1'b0,26'h0,  1'b0,32'h0,         32'h40,       32'd16,1'b0,32'h10,       1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h44,       32'd17,1'b0,32'h40,       1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,32'h200,      1'b1,26'h123,1'b1,32'h80,        32'h80,       32'd0, 1'b1,32'h44,       1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h84,       32'd1, 1'b1,32'h80,       1'b1,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b1,32'h4,         32'h4,        32'd1, 1'b0,32'h84,       1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h8,        32'd2, 1'b0,32'h4,        1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h8,        32'd2, 1'b0,32'h4,        1'b1,1'b0};
        vecs[12] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h8,        32'd2, 1'b0,32'h4,        1'b1,1'b0};
        vecs[13] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h8,        32'd2, 1'b0,32'h4,        1'b1,1'b0};
        vecs[14] = '{1'b0,1'b1,1'b1,32'h20,       1'b0,26'h0,  1'b0,32'h0,         32'h20,       32'd8, 1'b0,32'h8,        1'b0,1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h24,       32'd9, 1'b0,32'h20,       1'b1,1'b0};
        vecs[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b1,32'h33,        32'h30,       32'd12,1'b0,32'h24,       1'b0,1'b1};
        vecs[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h34,       32'd13,1'b0,32'h30,       1'b1,1'b1};
        vecs[18] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b1,32'hFFFF_FFFC, 32'hFFFF_FFFC,32'd31,1'b1,32'h34,       1'b0,1'b1};
        vecs[19] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h0,        32'd0, 1'b0,32'hFFFF_FFFC,1'b1,1'b1};
        vecs[20] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,26'h10, 1'b0,32'h0,         32'h40,       32'd16,1'b0,32'h0,        1'b0,1'b1};
        vecs[21] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,26'h0,  1'b1,32'h100,       32'h0,        32'd0, 1'b0,32'h0,        1'b0,1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,26'h0,  1'b0,32'h0,         32'h4,        32'd1, 1'b0,32'h0,        1'b1,1'b0};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].bt,
                  vecs[i].jmp, vecs[i].ji, vecs[i].jrr, vecs[i].jt);
            $display("vec %0d: pc=%h imem=%0d oor=%0b fpc=%h fv=%0b mis=%0b",
                     i, pc, imem_addr, pc_oor, fetch_pc, fetch_valid, misalign_err);
            check("vec_pc", pc, vecs[i].e_pc);
            check("vec_imem_addr", imem_addr, vecs[i].e_imem);
            check("vec_pc_oor", 32'(pc_oor), 32'(vecs[i].e_oor));
            check("vec_fetch_pc", fetch_pc, vecs[i].e_fpc);
            check("vec_fetch_pc_plus4", fetch_pc_plus4, vecs[i].e_fpc + 32'd4);
            check("vec_fetch_valid", 32'(fetch_valid), 32'(vecs[i].e_fv));
            check("vec_misalign_err", 32'(misalign_err), 32'(vecs[i].e_mis));
        end

        // Randomized traffic against the model, starting from a reset.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        compare_model();
        for (int n = 0; n < NRAND; n++) begin
            logic        r_rst;
            logic        r_stl;
            logic        r_br;
            logic        r_jmp;
            logic        r_jr;
            logic [31:0] r_bt;
            logic [31:0] r_jt;
            logic [25:0] r_ji;
            r_rst = ($urandom_range(0, 63) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_jmp = ($urandom_range(0, 9) == 0);
            r_jr  = ($urandom_range(0, 9) == 0);
            r_bt  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            r_jt  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
            r_ji  = 26'($urandom);
            drive(r_rst, r_stl, r_br, r_bt, r_jmp, r_ji, r_jr, r_jt);
            model_step(r_rst, r_stl, r_br, r_bt, r_jmp, r_ji, r_jr, r_jt);
            $display("rnd %0d: rst=%0b stl=%0b br=%0b jmp=%0b jr=%0b pc=%h fpc=%h fv=%0b mis=%0b",
                     n, r_rst, r_stl, r_br, r_jmp, r_jr, pc, fetch_pc, fetch_valid, misalign_err);
            compare_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
